serial_adder_subtractor: RTL and testbench



---
 rtl/serial_adder_subtractor.sv | 73 +++++++
 tb/tb_serial_adder_subtractor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_subtractor.sv
// serial_adder_subtractor: digit-serial signed add/subtract, LSB digit first, with optional saturation.
module serial_adder_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             carry_out
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] op_a, op_b, acc, raw;
  logic sat, sign_a, carry, last, cin_msb, ovf;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] dsum;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? CALC : IDLE) : state == CALC ? (last ? DONE : CALC) : IDLE;
    busy = state == CALC;
    done = state == DONE;
  end
  // On the last step the low operand digit holds the MSB, so sum^a^b at that bit is the carry into it.
  always_comb begin
    dsum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    raw = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
    last = cnt == CW'(STEPS - 1);
    cin_msb = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
    ovf = cin_msb ^ dsum[DIGIT];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      acc <= '0;
      sat <= 1'b0;
      sign_a <= 1'b0;
      carry <= 1'b0;
      cnt <= '0;
      s <= '0;
      overflow <= 1'b0;
      carry_out <= 1'b0;
    end else if (state == IDLE && start) begin
      op_a <= a;
      op_b <= b ^ {WIDTH{mode[0]}};
      sat <= mode[1];
      sign_a <= a[WIDTH-1];
      carry <= mode[0];
      cnt <= '0;
    end else if (state == CALC) begin
      op_a <= op_a >> DIGIT;
      op_b <= op_b >> DIGIT;
      acc <= raw;
      carry <= dsum[DIGIT];
      cnt <= cnt + CW'(1);
      if (last) begin
        s <= (sat && ovf) ? (sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : raw;
        overflow <= ovf;
        carry_out <= dsum[DIGIT];
      end
    end
endmodule

// File: tb/tb_serial_adder_subtractor.sv
// tb_serial_adder_subtractor: directed and random checks of the serial adder/subtractor against an arithmetic model.
module tb_serial_adder_subtractor;
  logic clk = 0, reset = 0, start = 0;
  logic [7:0] a = 0, b = 0, s, s2;
  logic [1:0] mode = 0;
  logic busy, done, overflow, carry_out, busy2, done2, ovf2, cout2;
  int n_cmp = 0, n_bad = 0;
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(2)) dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .mode(mode), .busy(busy), .done(done), .s(s), .overflow(overflow), .carry_out(carry_out));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(8)) dut2 (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .mode(mode), .busy(busy2), .done(done2), .s(s2), .overflow(ovf2), .carry_out(cout2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // Returns {overflow, carry_out, s} from exact integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
    int sx, sy, ex;
    bit o, c;
    logic [7:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ex = m[0] ? sx - sy : sx + sy;
    o = ex > 127 || ex < -128;
    c = m[0] ? (int'(x) >= int'(y)) : (int'(x) + int'(y) > 255);
    r = ex[7:0];
    if (o && m[1]) r = ex > 0 ? 8'h7f : 8'h80;
    return {o, c, r};
  endfunction
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input string tag);
    logic [9:0] e;
    logic [7:0] s_prev;
    int n1, n2;
    e = model(x, y, m);
    s_prev = s;
    n1 = 0;
    n2 = 0;
    @(negedge clk);
    a = x; b = y; mode = m; start = 1;
    @(posedge clk);
    #1 start = 0;
    a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
    for (int n = 0; n < 12; n++) begin
      chk({tag, "_excl"}, busy & done, 0);
      if (done2 && n2 == 0) begin
        n2 = n;
        chk({tag, "_s2"}, s2, e[7:0]);
        chk({tag, "_ovf2"}, ovf2, e[9]);
        chk({tag, "_cout2"}, cout2, e[8]);
      end
      if (done) begin
        n1 = n;
        break;
      end
      if (n < 4) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_hold"}, s, s_prev);
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, n1, 4);
    chk({tag, "_lat2"}, n2, 1);
    chk({tag, "_s"}, s, e[7:0]);
    chk({tag, "_ovf"}, overflow, e[9]);
    chk({tag, "_cout"}, carry_out, e[8]);
    @(posedge clk);
    #1 chk({tag, "_done_low"}, done, 0);
  endtask
  initial begin
    logic [17:0] q[$];
    logic [17:0] cap;
    logic [9:0] e;
    logic [7:0] last_s;
    #1 reset = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cout", carry_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    run_op(8'd5, 8'd7, 2'b00, "add_5_7");
    run_op(8'd100, 8'd50, 2'b00, "ovf_wrap");
    run_op(8'd100, 8'd50, 2'b10, "ovf_sat");
    run_op(8'd1, 8'h80, 2'b01, "sub_min");
    run_op(8'd1, 8'h80, 2'b11, "sub_min_sat");
    run_op(8'hFD, 8'hFA, 2'b01, "sub_neg");
    run_op(8'h9C, 8'hC4, 2'b10, "neg_sat");
    run_op(8'h9C, 8'hC4, 2'b00, "neg_wrap");
    for (int i = 0; i < 30; i++)
      run_op(8'($urandom), 8'($urandom), 2'($urandom), "rand");
    @(negedge clk);
    start = 1;
    a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
    last_s = s;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk);
      if (j % 6 == 0) q.push_back({a, b, mode});
      #1;
      if (j % 6 == 4) begin
        cap = q.pop_front();
        e = model(cap[17:10], cap[9:2], cap[1:0]);
        chk("held_done", done, 1);
        chk("held_s", s, e[7:0]);
        chk("held_ovf", overflow, e[9]);
        chk("held_cout", carry_out, e[8]);
        last_s = e[7:0];
      end else begin
        chk("held_nodone", done, 0);
        chk("held_stable", s, last_s);
      end
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
    end
    start = 0;
    @(posedge clk);
    #1;
    run_op(8'd100, 8'd50, 2'b00, "pre_abort");
    @(negedge clk);
    a = 8'd5; b = 8'd7; mode = 2'b00; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_s", s, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_cout", carry_out, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 chk("abort_nodone", done | done2, 0);
    end
    @(negedge clk);
    reset = 0;
    run_op(8'hFB, 8'd5, 2'b00, "post_reset");
    run_op(8'd5, 8'd7, 2'b00, "rerun_5_7");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
